// File: rtl/seed_storage_pkg.sv
// Shared types and constants for the seed storage bank.
// SEED_STORAGE_WIPE_EN widens op to 2 bits and adds the WIPE command.
package seed_storage_pkg;

`ifdef SEED_STORAGE_WIPE_EN
    localparam int OpBits = 2;
    localparam logic [OpBits-1:0] OpOut  = 2'b00;
    localparam logic [OpBits-1:0] OpIn   = 2'b01;
    localparam logic [OpBits-1:0] OpWipe = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IN   = 2'd1,
        OUT  = 2'd2,
        WIPE = 2'd3
    } stateT;
`else
    localparam int OpBits = 1;
    localparam logic [OpBits-1:0] OpOut = 1'b0;
    localparam logic [OpBits-1:0] OpIn  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IN   = 2'd1,
        OUT  = 2'd2
    } stateT;
`endif

    function automatic int slotBitsOf(input int slots);
        return (slots > 2) ? $clog2(slots) : 1;
    endfunction

    // cmd is {slot, op}, op in the low bits
    function automatic int cmdSizeOf(input int slots);
        return slotBitsOf(slots) + OpBits;
    endfunction

endpackage

// File: rtl/seed_storage_cmd_fifo.sv
// Two-entry command buffer with isReady/canReceive handshakes.
// Head entry is always mem[0]; a pop shifts mem[1] down.
module seed_storage_cmd_fifo #(
    parameter int BusSize = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BusSize-1:0] pushData,
    input  logic               pushValid,
    output logic               pushReady,
    output logic [BusSize-1:0] popData,
    output logic               popValid,
    input  logic               popReady
);

    logic [BusSize-1:0] mem [2];
    logic [1:0] count;
    logic       started;
    logic       doPush;
    logic       doPop;
    logic       wrIdx;

    // started keeps canReceive low until the first edge after reset
    assign pushReady = started && (count != 2'd2);
    assign popValid  = (count != 2'd0);
    assign popData   = mem[0];
    assign doPush    = pushValid && pushReady;
    assign doPop     = popReady && popValid;
    assign wrIdx     = (count == 2'd1) && !doPop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= 2'd0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            count   <= count + {1'b0, doPush} - {1'b0, doPop};
        end
    end

    always_ff @(posedge clk) begin
        if (doPop) mem[0] <= mem[1];
        if (doPush) mem[wrIdx] <= pushData;
    end

endmodule

// File: rtl/seed_storage_bank.sv
// Multi-slot seed store: buffered commands stream seeds in/out 64 bits a beat.
// Build option SEED_STORAGE_WIPE_EN adds a one-cycle slot WIPE command.
module seed_storage_bank
    import seed_storage_pkg::*;
#(
    parameter int WordCount = 2,
    parameter int Slots     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [cmdSizeOf(Slots)-1:0]  cmd,
    input  logic                         cmd_isReady,
    output logic                         cmd_canReceive,
    input  logic [63:0]                  in,
    input  logic                         in_isReady,
    output logic                         in_canReceive,
    output logic                         in_isLast,
    output logic [63:0]                  out,
    output logic                         out_isReady,
    input  logic                         out_canReceive,
    output logic                         out_isLast
);

    localparam int SlotBits = slotBitsOf(Slots);
    localparam int CmdSize  = cmdSizeOf(Slots);
    localparam int CntBits  = (WordCount > 1) ? $clog2(WordCount) : 1;
    localparam logic [CntBits-1:0]  LastWord  = CntBits'(WordCount - 1);
    localparam logic [SlotBits:0]   SlotLimit = (SlotBits + 1)'(Slots);

    logic [CmdSize-1:0]  head;
    logic                headValid;
    logic                pop;
    logic [OpBits-1:0]   headOp;
    logic [SlotBits-1:0] headSlot;
    logic                slotOk;

    stateT               stateQ;
    stateT               stateD;
    logic [SlotBits-1:0] slotQ;
    logic [CntBits-1:0]  cntQ;
    logic                atLast;
    logic                inBeat;
    logic                outBeat;

    logic [63:0] mem [Slots][WordCount];

    seed_storage_cmd_fifo #(
        .BusSize(CmdSize)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .pushData (cmd),
        .pushValid(cmd_isReady),
        .pushReady(cmd_canReceive),
        .popData  (head),
        .popValid (headValid),
        .popReady (pop)
    );

    assign headOp   = head[OpBits-1:0];
    assign headSlot = head[OpBits +: SlotBits];
    assign slotOk   = {1'b0, headSlot} < SlotLimit;

    assign atLast  = (cntQ == LastWord);
    assign inBeat  = (stateQ == IN) && in_isReady;
    assign outBeat = (stateQ == OUT) && out_canReceive;

    assign in_canReceive = (stateQ == IN);
    assign in_isLast     = (stateQ == IN) && atLast;
    assign out_isReady   = (stateQ == OUT);
    assign out_isLast    = (stateQ == OUT) && atLast;
    assign out           = mem[slotQ][cntQ];

    always_comb begin
        stateD = stateQ;
        pop    = 1'b0;
        unique case (stateQ)
            IDLE: begin
                if (headValid) begin
                    pop = 1'b1;
                    // out-of-range slots and unused ops just drain
                    if (slotOk) begin
                        case (headOp)
                            OpIn:    stateD = IN;
                            OpOut:   stateD = OUT;
`ifdef SEED_STORAGE_WIPE_EN
                            OpWipe:  stateD = WIPE;
`endif
                            default: stateD = IDLE;
                        endcase
                    end
                end
            end
            IN: begin
                if (inBeat && atLast) stateD = IDLE;
            end
            OUT: begin
                if (outBeat && atLast) stateD = IDLE;
            end
`ifdef SEED_STORAGE_WIPE_EN
            WIPE: stateD = IDLE;
`endif
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= IDLE;
            cntQ   <= '0;
            slotQ  <= '0;
        end else begin
            stateQ <= stateD;
            if (pop) slotQ <= headSlot;
            if (stateQ == IDLE) begin
                cntQ <= '0;
            end else if (inBeat || outBeat) begin
                cntQ <= atLast ? '0 : cntQ + 1'b1;
            end
        end
    end

    // Seed contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (inBeat) mem[slotQ][cntQ] <= in;
`ifdef SEED_STORAGE_WIPE_EN
        if (stateQ == WIPE) begin
            for (int w = 0; w < WordCount; w++) mem[slotQ][w] <= '0;
        end
`endif
    end

endmodule
